// File: rtl/mem_req_issuer.sv
// Issues accepted single-word requests as three-beat bursts on per-target ports.
// First beat one cycle after accept when the port is ready; req_ready is low while the target engine is busy.

module mem_req_engine #(
   parameter int KIND = 0,
   parameter int DW   = (KIND == 0) ? 2 : (KIND == 1) ? 4 : 1,
   parameter int LW   = (KIND == 2) ? 3 : 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          accept,
   input  logic [LW-1:0] req_data,
   input  logic          ch_ready,
   output logic          idle,
   output logic          cool,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);
   typedef enum logic [2:0] {IDLE, WAIT, B1, B2, B3, COOL} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         IDLE: if (accept) begin
            lat_d   = req_data;
            state_d = ch_ready ? B1 : WAIT;
         end
         WAIT:    if (ch_ready) state_d = B1;
         B1:      state_d = B2;
         B2:      state_d = B3;
         B3:      state_d = COOL;
         COOL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == B1) || (state_d == B2) || (state_d == B3);
   end

   // Beat data is decoded from the next state so valid and data register together.
   if (KIND == 0) begin : g_sdram
      always_comb begin
         data_d = '0;
         case (state_d)
            B1:      data_d = lat_d[1:0];
            B2:      data_d = lat_d[3:2];
            default: data_d = '0;
         endcase
      end
   end else if (KIND == 1) begin : g_flash
      always_comb data_d = valid_d ? lat_d : '0;
   end else begin : g_rom
      always_comb begin
         data_d = '0;
         case (state_d)
            B1:      data_d = lat_d[0];
            B2:      data_d = lat_d[1];
            B3:      data_d = lat_d[2];
            default: data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lat_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign idle    = (state_q == IDLE);
   assign cool    = (state_q == COOL);
   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

module mem_req_issuer #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_target,
   input  logic [3:0]       req_data,
   output logic             sdram_valid,
   output logic [1:0]       sdram_data_o,
   input  logic             sdram_ready,
   output logic             flash_valid,
   output logic [3:0]       flash_data_o,
   input  logic             flash_ready,
   output logic             rom_valid,
   output logic [0:0]       rom_data_o,
   input  logic             rom_ready,
   output logic [CNT_W-1:0] done_count,
   output logic             err_sticky
);
   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [2:0]       idle, cool, accept;
   logic [1:0]       cool_sum;
   logic [CNT_W:0]   done_ext;
   logic [CNT_W-1:0] done_q, done_d;
   logic             err_q, err_d;

   always_comb begin
      req_ready = 1'b1;
      case (req_target)
         2'd0:    req_ready = idle[0];
         2'd1:    req_ready = idle[1];
         2'd2:    req_ready = idle[2];
         default: req_ready = 1'b1;
      endcase
   end

   assign accept[0] = req_valid && req_ready && (req_target == 2'd0);
   assign accept[1] = req_valid && req_ready && (req_target == 2'd1);
   assign accept[2] = req_valid && req_ready && (req_target == 2'd2);

   mem_req_engine #(.KIND(0)) u_sdram (
      .clock(clock), .reset_n(reset_n), .accept(accept[0]), .req_data(req_data),
      .ch_ready(sdram_ready), .idle(idle[0]), .cool(cool[0]),
      .valid_o(sdram_valid), .data_o(sdram_data_o)
   );

   mem_req_engine #(.KIND(1)) u_flash (
      .clock(clock), .reset_n(reset_n), .accept(accept[1]), .req_data(req_data),
      .ch_ready(flash_ready), .idle(idle[1]), .cool(cool[1]),
      .valid_o(flash_valid), .data_o(flash_data_o)
   );

   // ROM only ever sends three bits, so the top payload bit is never latched.
   mem_req_engine #(.KIND(2)) u_rom (
      .clock(clock), .reset_n(reset_n), .accept(accept[2]), .req_data(req_data[2:0]),
      .ch_ready(rom_ready), .idle(idle[2]), .cool(cool[2]),
      .valid_o(rom_valid), .data_o(rom_data_o)
   );

   always_comb begin
      err_d    = err_q || (req_valid && (req_target == 2'd3));
      cool_sum = 2'(cool[0]) + 2'(cool[1]) + 2'(cool[2]);
      done_ext = {1'b0, done_q} + {{(CNT_W-1){1'b0}}, cool_sum};
      done_d   = (done_ext > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : done_ext[CNT_W-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done_q <= '0;
         err_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign done_count = done_q;
   assign err_sticky = err_q;
endmodule

// File: doc/mem_req_issuer.md
Name: mem_req_issuer

Overview:
- Upstream request stage for the memory controller.
- Accepts single-word write requests tagged with a target (SDRAM, flash or ROM) on a valid/ready port.
- Serialises each request into the multi-beat valid protocol that each controller port expects.
- Runs one independent issue engine per target, so all three controller ports can be driven in parallel. It also counts completed transactions and flags illegal targets.

Parameters:
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when req_valid&req_ready
- req_target  input  2  0=SDRAM, 1=flash, 2=ROM, 3=illegal
- req_data  input  4  payload
- sdram_valid  output  1  SDRAM beat valid
- sdram_data_o  output  2  SDRAM beat data
- sdram_ready  input  1  SDRAM controller not busy
- flash_valid  output  1  flash beat valid
- flash_data_o  output  4  flash beat data
- flash_ready  input  1  flash controller not busy
- rom_valid  output  1  ROM beat valid
- rom_data_o  output  1  ROM beat data
- rom_ready  input  1  ROM controller not busy
- done_count  output  CNT_W  completed sequences, saturating
- err_sticky  output  1  set once an illegal-target request has been accepted

Behaviour:
- Reset (reset_n low, asynchronous):
  - All engines go to IDLE; latched data is cleared.
  - All *_valid and *_data_o outputs are 0.
  - done_count=0, err_sticky=0.
  - Reset asserted mid-sequence aborts the sequence immediately; valid drops in the same instant.
- req_ready (combinational):
  - For target 0/1/2: 1 iff that target's engine is in IDLE.
  - For target 3: always 1.
- Illegal-target request: an accepted request with target 3 is dropped and err_sticky is set from the next cycle.
- Per-engine states: IDLE, WAIT, B1, B2, B3, COOL.
  - IDLE, on accept: req_data is latched. Go to B1 if the channel's *_ready is 1 in the accept cycle, else WAIT.
  - WAIT: go to B1 on the first cycle *_ready=1.
  - B1 -> B2 -> B3 unconditionally, one cycle each. *_valid=1 in B1, B2 and B3 only.
  - *_ready is ignored during B1..B3, because the controller never goes busy mid-receive.
  - B3 -> COOL. COOL holds *_valid=0 for one cycle while the controller is busy, then goes to IDLE.
- Latency: the first beat appears in the cycle after accept when the controller is ready. One request occupies a channel for 5 cycles, from accept to the return to IDLE.
- Beat data by channel:
  - SDRAM: B1=data[1:0], B2=data[3:2], B3=2'b00.
  - Flash: data[3:0] held in B1, B2 and B3.
  - ROM: B1=data[0], B2=data[1], B3=data[2]; data[3] is discarded.
- All *_data_o outputs are 0 whenever the corresponding *_valid is 0.
- done_count:
  - Adds the number of engines in COOL this cycle (0..3).
  - Saturates at 2^CNT_W-1; it never wraps.
- Simultaneous requests on different channels are only possible over consecutive cycles, since there is a single request port. Engines never interact.

Test Plan:
- SDRAM request, data=4'hB, sdram_ready=1 -> sdram_valid high for cycles N+1..N+3 with sdram_data_o=3,2,0; low at N+4; req_ready for target 0 returns 1 at N+5; done_count=1.
- Flash request, data=4'h6, flash_ready held 0 for 3 cycles -> engine stays in WAIT, no valid; once ready=1, three beats of 6 follow.
- ROM request, data=4'hD -> rom_data_o=1,0,1; then an SDRAM request issued while ROM is in B2 -> both streams overlap correctly; done_count=2.
- Target=3 request -> req_ready=1, no valid on any port, err_sticky=1 next cycle and held; done_count unchanged.
- Assert reset_n low during flash B2 -> flash_valid=0 immediately; after release, state is IDLE, done_count=0 and req_ready=1 for all targets.
- CNT_W=2, five SDRAM requests back to back -> done_count steps 1,2,3,3,3.
